// File: rtl/index_gen_pkg.sv
// Shared widths, state encoding, rotation-rate presets and config validity check
// for the INDEX pulse generator.
package index_gen_pkg;

    localparam int PERIOD_W = 27;
    localparam int WIDTH_W  = 24;
    localparam int REV_W    = 16;
    localparam int LFSR_W   = 16;

    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam logic [PERIOD_W-1:0] FLOPPY_300_PERIOD   = 27'd60_000_000;
    localparam logic [PERIOD_W-1:0] FLOPPY_360_PERIOD   = 27'd50_000_000;
    localparam logic [PERIOD_W-1:0] HDD_3600_PERIOD     = 27'd5_000_000;
    localparam logic [PERIOD_W-1:0] HDD_3000_PERIOD     = 27'd6_000_000;
    localparam logic [WIDTH_W-1:0]  DEFAULT_INDEX_WIDTH = 24'd600_000;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } gen_state_t;

    function automatic logic cfg_valid(input logic [PERIOD_W-1:0] period,
                                       input logic [WIDTH_W-1:0]  width);
        return (width != '0) && (period >= PERIOD_W'(2)) && (PERIOD_W'(width) < period);
    endfunction

endpackage

// File: rtl/index_jitter_lfsr.sv
// 16-bit Galois LFSR that advances once per step strobe; feeds the INDEX period jitter.
module index_jitter_lfsr
    import index_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    output logic [LFSR_W-1:0] lfsr
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (step) begin
            lfsr <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
        end
    end

endmodule

// File: rtl/index_pulse_gen.sv
// Periodic INDEX pulse generator with double-buffered period/width applied on
// revolution boundaries. Optional period jitter under INDEX_GEN_JITTER_EN.
module index_pulse_gen
    import index_gen_pkg::*;
#(
    parameter int                JITTER_MAX = 255,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                gen_enable,
    input  logic [PERIOD_W-1:0] period_cfg,
    input  logic [WIDTH_W-1:0]  width_cfg,
    input  logic                cfg_update,
    output logic                index_out,
    output logic                active,
    output logic [REV_W-1:0]    rev_count,
    output logic                cfg_error
);

    gen_state_t          state, state_next;
    logic [PERIOD_W-1:0] shadow_period, act_period, phase_cnt, reload_period;
    logic [WIDTH_W-1:0]  shadow_width, act_width, reload_width;
    logic [PERIOD_W:0]   period_eff;
    logic                pending, boundary_d;
    logic                shadow_ok, reload_ok, pulse_end, boundary, reload;

    // Elaboration-time guard: a zero seed would lock the LFSR.
    if (LFSR_SEED == '0 || JITTER_MAX < 0) begin : g_bad_param
        localparam int BAD_PARAM = 1;
    end

    assign shadow_ok     = cfg_valid(shadow_period, shadow_width);
    assign reload_period = cfg_update ? period_cfg : shadow_period;
    assign reload_width  = cfg_update ? width_cfg  : shadow_width;
    assign reload_ok     = cfg_valid(reload_period, reload_width);
    assign pulse_end     = (phase_cnt == PERIOD_W'(act_width) - PERIOD_W'(1));
    assign boundary      = (state == ST_GAP) && gen_enable
                        && ({1'b0, phase_cnt} == period_eff - (PERIOD_W+1)'(1));
    assign reload        = boundary && (pending || cfg_update);

`ifdef INDEX_GEN_JITTER_EN
    logic [LFSR_W-1:0] lfsr;
    int                jit, eff;

    index_jitter_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (boundary),
        .lfsr  (lfsr)
    );

    // Jitter only stretches/shrinks the gap; the pulse always fits with one gap clock.
    always_comb begin
        jit = int'($signed(lfsr));
        if (jit > JITTER_MAX) begin
            jit = JITTER_MAX;
        end else if (jit < -JITTER_MAX) begin
            jit = -JITTER_MAX;
        end
        eff = int'(act_period) + jit;
        if (eff < int'(act_width) + 1) begin
            eff = int'(act_width) + 1;
        end
        if (eff > (1 << PERIOD_W)) begin
            eff = 1 << PERIOD_W;
        end
        period_eff = (PERIOD_W+1)'(eff);
    end
`else
    assign period_eff = {1'b0, act_period};
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_OFF: begin
                if (gen_enable && shadow_ok) state_next = ST_PULSE;
            end
            ST_PULSE: begin
                if (!gen_enable)    state_next = ST_OFF;
                else if (pulse_end) state_next = ST_GAP;
            end
            ST_GAP: begin
                if (!gen_enable)   state_next = ST_OFF;
                else if (boundary) state_next = ST_PULSE;
            end
            default: state_next = ST_OFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_OFF;
            index_out     <= 1'b0;
            active        <= 1'b0;
            rev_count     <= '0;
            cfg_error     <= 1'b0;
            shadow_period <= '0;
            shadow_width  <= '0;
            act_period    <= '0;
            act_width     <= '0;
            phase_cnt     <= '0;
            pending       <= 1'b0;
            boundary_d    <= 1'b0;
        end else begin
            state      <= state_next;
            // Outputs trail the state by one clock; dropping enable kills them at once.
            index_out  <= (state == ST_PULSE) && gen_enable;
            active     <= (state != ST_OFF) && gen_enable;
            boundary_d <= boundary;
            if (boundary_d) rev_count <= rev_count + REV_W'(1);

            if (cfg_update) begin
                shadow_period <= period_cfg;
                shadow_width  <= width_cfg;
            end

            if (state == ST_OFF || boundary) pending <= 1'b0;
            else if (cfg_update)             pending <= 1'b1;

            if (state == ST_OFF || !gen_enable || boundary) phase_cnt <= '0;
            else                                           phase_cnt <= phase_cnt + PERIOD_W'(1);

            if (state == ST_OFF) begin
                if (gen_enable) begin
                    if (shadow_ok) begin
                        act_period <= shadow_period;
                        act_width  <= shadow_width;
                    end else begin
                        cfg_error <= 1'b1;
                    end
                end
            end else if (!gen_enable) begin
                cfg_error <= 1'b0;
            end else if (reload) begin
                if (reload_ok) begin
                    act_period <= reload_period;
                    act_width  <= reload_width;
                    cfg_error  <= 1'b0;
                end else begin
                    cfg_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_index_pulse_gen.sv
// Directed bench for index_pulse_gen: a negedge monitor checks pulse widths and
// rising-edge spacing against expectations queued by the stimulus.
`timescale 1ns/1ps
module tb_index_pulse_gen;
    import index_gen_pkg::*;

`ifdef INDEX_GEN_JITTER_EN
    localparam int JIT = 16;
`else
    localparam int JIT = 0;
`endif

    typedef struct {
        int lo;
        int hi;
    } range_t;

    logic                clk        = 1'b0;
    logic                reset      = 1'b1;
    logic                gen_enable = 1'b0;
    logic                cfg_update = 1'b0;
    logic [PERIOD_W-1:0] period_cfg = '0;
    logic [WIDTH_W-1:0]  width_cfg  = '0;
    logic                index_out, active, cfg_error;
    logic [REV_W-1:0]    rev_count;

    int     checks   = 0;
    int     failures = 0;
    range_t exp_period_q[$];
    int     exp_width_q[$];
    bit     mon_en    = 1'b0;
    bit     have_rise = 1'b0;
    logic   prev_idx  = 1'b0;
    int     cyc = 0, last_rise = 0, rise_cnt = 0;
    int     seen_min = 0, seen_max = 0;
    int     base;

    index_pulse_gen #(.JITTER_MAX(16), .LFSR_SEED(16'hACE1)) dut (
        .clk        (clk),
        .reset      (reset),
        .gen_enable (gen_enable),
        .period_cfg (period_cfg),
        .width_cfg  (width_cfg),
        .cfg_update (cfg_update),
        .index_out  (index_out),
        .active     (active),
        .rev_count  (rev_count),
        .cfg_error  (cfg_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        range_t er;
        int     p, w;
        cyc++;
        if (active !== 1'b1) have_rise = 1'b0;
        if (index_out === 1'b1 && prev_idx !== 1'b1) begin
            if (have_rise && mon_en) begin
                p = cyc - last_rise;
                if (p < seen_min) seen_min = p;
                if (p > seen_max) seen_max = p;
                if (exp_period_q.size() > 0) begin
                    er = exp_period_q.pop_front();
                    checks++;
                    assert (p >= er.lo && p <= er.hi) else begin
                        failures++;
                        $error("FAIL period observed=%0d expected=%0d..%0d", p, er.lo, er.hi);
                    end
                end
            end
            last_rise = cyc;
            have_rise = 1'b1;
            rise_cnt++;
        end else if (index_out !== 1'b1 && prev_idx === 1'b1 && mon_en && exp_width_q.size() > 0) begin
            w = cyc - last_rise;
            p = exp_width_q.pop_front();
            checks++;
            assert (w === p) else begin
                failures++;
                $error("FAIL width observed=%0d expected=%0d", w, p);
            end
        end
        prev_idx = index_out;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int p, input int w);
        period_cfg = PERIOD_W'(p);
        width_cfg  = WIDTH_W'(w);
        cfg_update = 1'b1;
        tick(1);
        cfg_update = 1'b0;
    endtask

    task automatic push_exp(input int n_per, input int per, input int n_wid, input int wid);
        range_t r;
        r.lo = per - JIT;
        r.hi = per + JIT;
        for (int i = 0; i < n_per; i++) exp_period_q.push_back(r);
        for (int i = 0; i < n_wid; i++) exp_width_q.push_back(wid);
    endtask

    task automatic wait_rises(input int target, input int budget);
        int n = 0;
        while (rise_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        chk("rise_timeout", int'(rise_cnt >= target), 1);
    endtask

    task automatic wait_level(input logic lvl, input int budget);
        int n = 0;
        while (index_out !== lvl && n < budget) begin
            tick(1);
            n++;
        end
        chk("level_timeout", int'(index_out === lvl), 1);
    endtask

    task automatic drained();
        chk("period_q_drained", exp_period_q.size(), 0);
        chk("width_q_drained", exp_width_q.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        tick(3);
        chk("rst_index", index_out, 0);
        chk("rst_active", active, 0);
        chk("rst_rev", rev_count, 0);
        chk("rst_err", cfg_error, 0);
        reset = 1'b0;
        tick(2);

        // basic run: 1000/100, latency, widths, spacing, rev_count
        cfg(1000, 100);
        tick(2);
        chk("off_after_cfg_active", active, 0);
        chk("off_after_cfg_index", index_out, 0);
        push_exp(5, 1000, 6, 100);
        mon_en = 1'b1;
        base = rise_cnt;
        gen_enable = 1'b1;
        tick(1);
        chk("start_lat_index_n", index_out, 0);
        tick(1);
        chk("start_lat_index_n1", index_out, 1);
        chk("start_lat_active_n1", active, 1);
        wait_rises(base + 6, 7000);
        chk("rev_after_6", rev_count, 5);
        wait_level(1'b0, 200);
        drained();

        // mid-revolution update to 500/50
        wait_rises(base + 7, 1100);
        push_exp(1, 1000, 1, 100);
        push_exp(3, 500, 4, 50);
        tick(299);
        cfg(500, 50);
        wait_rises(base + 11, 3000);
        wait_level(1'b0, 200);
        drained();
        chk("rev_after_update", rev_count, 10);
        chk("err_after_update", cfg_error, 0);

        // disable mid-pulse
        mon_en = 1'b0;
        gen_enable = 1'b0;
        tick(2);
        chk("disable_gap_active", active, 0);
        chk("disable_gap_rev", rev_count, 10);
        cfg(1000, 100);
        gen_enable = 1'b1;
        wait_level(1'b1, 50);
        tick(39);
        gen_enable = 1'b0;
        tick(1);
        chk("disable_pulse_index", index_out, 0);
        chk("disable_pulse_active", active, 0);
        chk("disable_pulse_rev", rev_count, 10);
        tick(2);
        push_exp(1, 1000, 2, 100);
        mon_en = 1'b1;
        base = rise_cnt;
        gen_enable = 1'b1;
        wait_rises(base + 2, 2500);
        wait_level(1'b0, 200);
        drained();
        chk("reenable_rev", rev_count, 11);

        // reset mid-gap
        mon_en = 1'b0;
        base = rise_cnt;
        wait_rises(base + 1, 1100);
        tick(699);
        reset = 1'b1;
        gen_enable = 1'b0;
        #1;
        chk("async_rst_index", index_out, 0);
        chk("async_rst_active", active, 0);
        chk("async_rst_rev", rev_count, 0);
        chk("async_rst_err", cfg_error, 0);
        tick(2);
        reset = 1'b0;
        tick(20);
        chk("post_rst_active", active, 0);
        chk("post_rst_index", index_out, 0);
        chk("post_rst_rev", rev_count, 0);

        // invalid config at enable, then valid restart
        cfg(1000, 1000);
        gen_enable = 1'b1;
        tick(1);
        chk("invalid_err_set", cfg_error, 1);
        tick(5);
        chk("invalid_active", active, 0);
        chk("invalid_index", index_out, 0);
        chk("invalid_err_hold", cfg_error, 1);
        gen_enable = 1'b0;
        tick(1);
        cfg(1000, 100);
        push_exp(1, 1000, 2, 100);
        mon_en = 1'b1;
        base = rise_cnt;
        gen_enable = 1'b1;
        wait_rises(base + 2, 2500);
        wait_level(1'b0, 200);
        drained();

        // long run: period bounds, width fixed, jitter spread
        seen_min = 1 << 30;
        seen_max = 0;
        push_exp(64, 1000, 64, 100);
        base = rise_cnt;
        wait_rises(base + 64, 70000);
        wait_level(1'b0, 200);
        drained();
`ifdef INDEX_GEN_JITTER_EN
        chk("jitter_distinct", int'(seen_max > seen_min), 1);
`else
        chk("period_min_exact", seen_min, 1000);
        chk("period_max_exact", seen_max, 1000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
